cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Triggered capture buffer downstream of `cpu_top`. It samples the 32-bit `op` debug/status bus every clock, waits for an armed trigger match, then stores consecutive words in an internal FIFO. A debug host drains the FIFO through a first-word-fall-through valid/ready port. All logic runs in the CPU clock domain.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 4.
- `WIDTH`, 32: captured word width; matches `cpu_top.op`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `op_in` input WIDTH: `cpu_top.op`, sampled every rising edge.
- `arm` input 1: one-cycle pulse; IDLE→ARMED.
- `clear` input 1: one-cycle pulse; flush FIFO, clear `overflow`, go to IDLE.
- `trig_value` input WIDTH: trigger compare value.
- `trig_mask` input WIDTH: 1 = bit participates in compare.
- `out_data` output WIDTH: FIFO head word; valid only while `out_valid`=1.
- `out_valid` output 1: FIFO not empty.
- `out_ready` input 1: host accepts head word.
- `count` output $clog2(DEPTH)+1: words currently stored.
- `state` output 2: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- `overflow` output 1: sticky; a capture word was dropped.

## Operation
- Trigger hit: `(op_in & trig_mask) == (trig_value & trig_mask)`. A zero mask hits on the first ARMED cycle.
- Pop: `out_valid && out_ready`. Pops are legal in every state.
- Push: write `op_in` at `wr_ptr`. Allowed when `count<DEPTH` or when a pop occurs in the same cycle.
- State transitions:
  - IDLE: `arm` → ARMED. No pushes.
  - ARMED: trigger hit → CAPTURE, and the hit word is pushed in that cycle. `arm` while ARMED has no effect.
  - CAPTURE: push `op_in` every cycle. If a push is required while full and no pop occurs, drop the word, set `overflow`, and go to DONE.
  - DONE: no pushes. Contents are held for draining. `arm` → ARMED without flushing.
- `clear` has priority over every other input in any state. Next cycle: `count`=0, pointers=0, `overflow`=0, state=IDLE. A pop in the same cycle as `clear` is discarded.
- `arm` in CAPTURE is ignored.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `count` is updated as +1 (push only), −1 (pop only), or unchanged (both or neither). It never exceeds DEPTH and never underflows.
- Trigger fields are used combinationally. The host must hold them stable while ARMED.

## Timing
- Reset values: `state`=IDLE, `count`=0, `out_valid`=0, `overflow`=0, pointers 0. `out_data` is don't-care while `out_valid`=0; the bench checks 0 because storage reads through a zeroed head.
- Capture latency: a word present on `op_in` at edge N appears on `out_data` with `out_valid`=1 after edge N when the FIFO was empty. `count` reflects the push after the same edge.
- First-word-fall-through: `out_data` changes only after a pop or after a push into an empty FIFO.
- A state change takes effect on the edge where its condition is sampled.
- Full with simultaneous pop in CAPTURE: the push succeeds, `count` stays DEPTH, and no overflow is flagged.
- Reset asserted mid-capture: same effect as `clear` plus reset values on the next edge.

## Configuration
- `TRACE_CHANGE_ONLY_EN` defined: in CAPTURE, push only when `op_in` differs from the previous cycle's `op_in`. The trigger word is always pushed. Repeated values are neither stored nor counted as overflow. The previous-value register resets to 0.
- `TRACE_CHANGE_ONLY_EN` undefined: push every CAPTURE cycle as described in Operation.

## Test plan
- Reset: assert `reset` 2 cycles with `op_in`=32'hFFFF_FFFF → `state`=0, `count`=0, `out_valid`=0, `overflow`=0.
- Masked trigger: `trig_mask`=32'h0000_03C0, `trig_value`=32'h0000_0080, `arm`. Drive `op_in` 32'h0000_0040, then 32'h1234_5088 → CAPTURE entered on 32'h1234_5088; first `out_data`=32'h1234_5088; the earlier word is never stored.
- Overflow: DEPTH=16, `out_ready`=0, incrementing `op_in` 1,2,3… after trigger at 1 → `count`=16, words 1..16 stored, word 17 dropped, `overflow`=1, `state`=DONE. Drain with `out_ready`=1 → 1..16 in order, then `out_valid`=0.
- Full plus pop: fill to 16, then hold `out_ready`=1 in CAPTURE → `count` stays 16, `overflow`=0, output is an in-order continuous sequence across pointer wrap.
- Clear mid-capture: after 5 words, pulse `clear` with `out_ready`=1 → next cycle `count`=0, `out_valid`=0, `state`=IDLE; a later `arm` re-triggers cleanly.
- `TRACE_CHANGE_ONLY_EN` defined: `op_in` sequence A,A,A,B,B,C after a trigger on A → FIFO holds A,B,C; `count`=3; `overflow`=0.

Source files
------------

// File: rtl/cpu_trace_buffer_if.sv
// Host-side bundle for cpu_trace_buffer: trigger setup, control pulses, FWFT drain port and status.
// The master modport is the debug host; the slave modport is the trace buffer.
interface cpu_trace_buffer_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] op_in;
    logic             arm;
    logic             clear;
    logic [WIDTH-1:0] trig_value;
    logic [WIDTH-1:0] trig_mask;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic [1:0]       state;
    logic             overflow;

    modport master (
        output op_in, arm, clear, trig_value, trig_mask, out_ready,
        input  out_data, out_valid, count, state, overflow
    );

    modport slave (
        input  op_in, arm, clear, trig_value, trig_mask, out_ready,
        output out_data, out_valid, count, state, overflow
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Triggered capture FIFO for the CPU op bus, drained through a first-word-fall-through port.
// Define TRACE_CHANGE_ONLY_EN to store only words that differ from the previous cycle's op_in.
module cpu_trace_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    cpu_trace_buffer_if.slave trace_if
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             hit, full, pop, want_push, push, changed;

`ifdef TRACE_CHANGE_ONLY_EN
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= trace_if.op_in;
        end
    end

    assign changed = (trace_if.op_in != prev_q);
`else
    assign changed = 1'b1;
`endif

    assign hit  = ((trace_if.op_in ^ trace_if.trig_value) & trace_if.trig_mask) == '0;
    assign full = (count_q == CW'(DEPTH));
    assign pop  = (count_q != '0) && trace_if.out_ready;

    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        want_push  = 1'b0;
        push       = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        unique case (state_q)
            StIdle: begin
                if (trace_if.arm) state_d = StArmed;
            end
            StArmed: begin
                if (hit) begin
                    want_push = 1'b1;
                    state_d   = StCapture;
                end
            end
            StCapture: begin
                want_push = changed;
            end
            StDone: begin
                if (trace_if.arm) state_d = StArmed;
            end
        endcase

        // A pop in the same cycle frees the slot the push needs.
        push = want_push && (!full || pop);
        if (want_push && !push) begin
            overflow_d = 1'b1;
            state_d    = StDone;
        end

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (trace_if.clear) begin
            state_d    = StIdle;
            overflow_d = 1'b0;
            push       = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (push) mem_q[wr_ptr_q] <= trace_if.op_in;
        end
    end

    assign trace_if.out_data  = mem_q[rd_ptr_q];
    assign trace_if.out_valid = (count_q != '0);
    assign trace_if.count     = count_q;
    assign trace_if.state     = state_q;
    assign trace_if.overflow  = overflow_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: a queue-based model checked every cycle, plus literal checks.
module tb_cpu_trace_buffer;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpu_trace_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) tif ();

    cpu_trace_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .trace_if (tif)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: a queue holds the stored words; state and overflow follow the capture rules.
    logic [31:0] mq[$];
    int          mstate    = 0;
    bit          movf      = 1'b0;
    logic [31:0] mprev     = '0;
    bit          model_ok  = 1'b0;

    always @(posedge clk) begin : model
        bit mpop;
        bit want;
        mpop = 1'b0;
        want = 1'b0;
        if (reset || tif.clear) begin
            mq.delete();
            mstate = 0;
            movf   = 1'b0;
        end else begin
            mpop = (mq.size() > 0) && tif.out_ready;
            case (mstate)
                0: if (tif.arm) mstate = 1;
                1: if ((tif.op_in & tif.trig_mask) == (tif.trig_value & tif.trig_mask)) begin
                    want   = 1'b1;
                    mstate = 2;
                end
`ifdef TRACE_CHANGE_ONLY_EN
                2: want = (tif.op_in != mprev);
`else
                2: want = 1'b1;
`endif
                default: if (tif.arm) mstate = 1;
            endcase
            if (mpop) void'(mq.pop_front());
            if (want) begin
                if (mq.size() < int'(DEPTH)) begin
                    mq.push_back(tif.op_in);
                end else begin
                    movf   = 1'b1;
                    mstate = 3;
                end
            end
        end
        mprev    = reset ? 32'h0 : tif.op_in;
        model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("cyc_state", 32'(tif.state), 32'(mstate));
            check("cyc_count", 32'(tif.count), 32'(mq.size()));
            check("cyc_valid", 32'(tif.out_valid), 32'(mq.size() > 0));
            check("cyc_overflow", 32'(tif.overflow), 32'(movf));
            if (mq.size() > 0) check("cyc_data", tif.out_data, mq[0]);
        end
    end

    task automatic pulse_clear();
        tif.clear = 1'b1;
        step();
        tif.clear = 1'b0;
    endtask

    task automatic arm_on(input logic [31:0] value, input logic [31:0] mask);
        tif.trig_value = value;
        tif.trig_mask  = mask;
        tif.op_in      = 32'h0;
        tif.arm        = 1'b1;
        step();
        tif.arm        = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        tif.op_in      = 32'hFFFF_FFFF;
        tif.arm        = 1'b0;
        tif.clear      = 1'b0;
        tif.trig_value = 32'h0;
        tif.trig_mask  = 32'h0;
        tif.out_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_state", 32'(tif.state), 32'd0);
        check("rst_count", 32'(tif.count), 32'd0);
        check("rst_valid", 32'(tif.out_valid), 32'd0);
        check("rst_overflow", 32'(tif.overflow), 32'd0);
        check("rst_data", tif.out_data, 32'h0);

        // Masked trigger: 0x40 misses, 0x1234_5088 hits on bits 9:6.
        arm_on(32'h0000_0080, 32'h0000_03C0);
        tif.op_in = 32'h0000_0040;
        step();
        check("mask_miss_state", 32'(tif.state), 32'd1);
        check("mask_miss_count", 32'(tif.count), 32'd0);
        tif.op_in = 32'h1234_5088;
        step();
        check("mask_hit_state", 32'(tif.state), 32'd2);
        check("mask_hit_data", tif.out_data, 32'h1234_5088);
        check("mask_hit_count", 32'(tif.count), 32'd1);
        pulse_clear();

        // Overflow: 1..16 stored, 17 dropped.
        arm_on(32'h1, 32'hFFFF_FFFF);
        for (int v = 1; v <= 20; v++) begin
            tif.op_in = 32'(v);
            step();
        end
        check("ovf_count", 32'(tif.count), 32'd16);
        check("ovf_flag", 32'(tif.overflow), 32'd1);
        check("ovf_state", 32'(tif.state), 32'd3);
        tif.op_in     = 32'h0;
        tif.out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            check("ovf_drain", tif.out_data, 32'(k));
            step();
        end
        check("ovf_empty", 32'(tif.out_valid), 32'd0);
        tif.out_ready = 1'b0;
        pulse_clear();
        check("clr_overflow", 32'(tif.overflow), 32'd0);

        // Full plus simultaneous pop keeps count at DEPTH across pointer wrap.
        arm_on(32'd100, 32'hFFFF_FFFF);
        for (int v = 100; v <= 115; v++) begin
            tif.op_in = 32'(v);
            step();
        end
        check("full_count", 32'(tif.count), 32'd16);
        tif.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tif.op_in = 32'(116 + i);
            check("full_pop_data", tif.out_data, 32'(100 + i));
            step();
            check("full_pop_count", 32'(tif.count), 32'd16);
            check("full_pop_ovf", 32'(tif.overflow), 32'd0);
        end
        check("full_pop_state", 32'(tif.state), 32'd2);
        tif.out_ready = 1'b0;
        pulse_clear();

        // Clear mid-capture with a same-cycle pop, then a clean re-trigger.
        arm_on(32'd200, 32'hFFFF_FFFF);
        for (int v = 200; v <= 204; v++) begin
            tif.op_in = 32'(v);
            step();
        end
        check("mid_count", 32'(tif.count), 32'd5);
        tif.op_in     = 32'd205;
        tif.out_ready = 1'b1;
        pulse_clear();
        tif.out_ready = 1'b0;
        check("mid_clr_count", 32'(tif.count), 32'd0);
        check("mid_clr_valid", 32'(tif.out_valid), 32'd0);
        check("mid_clr_state", 32'(tif.state), 32'd0);
        arm_on(32'd300, 32'hFFFF_FFFF);
        tif.op_in = 32'd300;
        step();
        check("rearm_state", 32'(tif.state), 32'd2);
        check("rearm_count", 32'(tif.count), 32'd1);
        check("rearm_data", tif.out_data, 32'd300);
        pulse_clear();

`ifdef TRACE_CHANGE_ONLY_EN
        // Repeats are neither stored nor counted as overflow.
        arm_on(32'hA, 32'hFFFF_FFFF);
        tif.op_in = 32'hA; step();
        tif.op_in = 32'hA; step();
        tif.op_in = 32'hA; step();
        tif.op_in = 32'hB; step();
        tif.op_in = 32'hB; step();
        tif.op_in = 32'hC; step();
        step();
        check("chg_count", 32'(tif.count), 32'd3);
        check("chg_ovf", 32'(tif.overflow), 32'd0);
        tif.out_ready = 1'b1;
        check("chg_d0", tif.out_data, 32'hA); step();
        check("chg_d1", tif.out_data, 32'hB); step();
        check("chg_d2", tif.out_data, 32'hC); step();
        check("chg_empty", 32'(tif.out_valid), 32'd0);
        tif.out_ready = 1'b0;
        pulse_clear();
`endif

        // Reset mid-capture behaves like clear plus reset values.
        arm_on(32'd400, 32'hFFFF_FFFF);
        for (int v = 400; v <= 403; v++) begin
            tif.op_in = 32'(v);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_state", 32'(tif.state), 32'd0);
        check("rst_mid_count", 32'(tif.count), 32'd0);
        check("rst_mid_valid", 32'(tif.out_valid), 32'd0);
        check("rst_mid_data", tif.out_data, 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
